matmul_operand_feeder: RTL

//  Upstream stage of the matmul core. Holds operand matrices A (N x K) and B (K x M) in local buffers.
//  On start, streams them as diagonally skewed element vectors into the west (A) and north (B) edges
//  of the MAX_DIM x MAX_DIM output-stationary systolic array.

---
 rtl/matmul_pkg.sv | 18 +
 rtl/matmul_operand_buf.sv | 25 ++
 rtl/matmul_operand_feeder.sv | 112 +++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes, element/vector/dimension types and feeder FSM states for the matmul core.
//  DATA_WIDTH element width, BUS_WIDTH operand row word width, MAX_DIM array side (elements per row word).
//  elem_of extracts element e of a row word (element e sits at bits [e*DATA_WIDTH +: DATA_WIDTH]).
package matmul_pkg;
  localparam int DATA_WIDTH = 4;
  localparam int BUS_WIDTH  = 16;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM);
  localparam int T_W        = $clog2(2 * MAX_DIM + 1);
  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [MAX_DIM-1:0] feed_vec_t;
  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [T_W-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feeder_state_e;
  function automatic elem_t elem_of(input logic [BUS_WIDTH-1:0] word, input dim_t e);
    return elem_t'(word >> (DATA_WIDTH * int'(e)));
  endfunction
endpackage

// File: rtl/matmul_operand_buf.sv
// matmul_operand_buf: MAX_DIM x BUS_WIDTH operand register file, one write port, MAX_DIM combinational element reads.
//  clk      in   clock
//  we       in   write strobe
//  row      in   row written
//  data     in   row word written
//  rd_row   in   per-lane row to read
//  rd_elem  in   per-lane element within that row
//  rd_data  out  per-lane element read
module matmul_operand_buf
  import matmul_pkg::*;
(
  input  logic                      clk,
  input  logic                      we,
  input  logic [DIM_W-1:0]          row,
  input  logic [BUS_WIDTH-1:0]      data,
  input  dim_t [MAX_DIM-1:0]        rd_row,
  input  dim_t [MAX_DIM-1:0]        rd_elem,
  output feed_vec_t                 rd_data
);
  logic [BUS_WIDTH-1:0] mem [MAX_DIM];
  always_ff @(posedge clk)
    if (we) mem[row] <= data;
  always_comb
    for (int i = 0; i < MAX_DIM; i++) rd_data[i] = elem_of(mem[rd_row[i]], rd_elem[i]);
endmodule

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder: buffers operands A (N x K) and B (K x M) and streams them diagonally skewed
//  into the west (A) and north (B) edges of the MAX_DIM x MAX_DIM output-stationary systolic array.
//  Optional feature: define MATMUL_FEEDER_STALL_EN to let stall_i freeze the feed in FEED/DRAIN.
//  clk_i, rst_ni             clock, synchronous active-low reset
//  op_we_i/op_sel_i/op_row_i/op_data_i   operand row write (IDLE only; sel 0=A, 1=B)
//  start_i, dim_n_i/dim_k_i/dim_m_i      start pulse and N-1/K-1/M-1 (latched on start)
//  stall_i                   feed freeze (only with MATMUL_FEEDER_STALL_EN)
//  a_feed_o, b_feed_o        west/north edge lanes
//  feed_valid_o              beat valid during FEED/DRAIN
//  acc_clr_o, busy_o, done_o accumulator clear pulse, not-idle, completion pulse
module matmul_operand_feeder
  import matmul_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          op_we_i,
  input  logic                          op_sel_i,
  input  logic [DIM_W-1:0]              op_row_i,
  input  logic [BUS_WIDTH-1:0]          op_data_i,
  input  logic                          start_i,
  input  logic [DIM_W-1:0]              dim_n_i,
  input  logic [DIM_W-1:0]              dim_k_i,
  input  logic [DIM_W-1:0]              dim_m_i,
  input  logic                          stall_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] a_feed_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] b_feed_o,
  output logic                          feed_valid_o,
  output logic                          acc_clr_o,
  output logic                          busy_o,
  output logic                          done_o
);
  feeder_state_e state_q, state_d;
  cnt_t t_q, t_d;
  dim_t n_q, k_q, m_q;
  feed_vec_t a_q, b_q, a_rd, b_rd;
  dim_t [MAX_DIM-1:0] a_row, a_elem, b_row, b_elem;
  logic [MAX_DIM-1:0] a_ok, b_ok;
  logic stall, feed_last, drain_last, wr;
`ifdef MATMUL_FEEDER_STALL_EN
  assign stall = stall_i && (state_q == FEED || state_q == DRAIN);
`else
  logic unused_stall;
  assign unused_stall = stall_i;
  assign stall = 1'b0;
`endif
  assign wr = op_we_i && state_q == IDLE;
  assign feed_last = t_q == cnt_t'(k_q) + cnt_t'(MAX_DIM - 1);
  assign drain_last = t_q == cnt_t'(MAX_DIM - 2);
  matmul_operand_buf u_a (.clk(clk_i), .we(wr && !op_sel_i), .row(op_row_i), .data(op_data_i),
                          .rd_row(a_row), .rd_elem(a_elem), .rd_data(a_rd));
  matmul_operand_buf u_b (.clk(clk_i), .we(wr && op_sel_i), .row(op_row_i), .data(op_data_i),
                          .rd_row(b_row), .rd_elem(b_elem), .rd_data(b_rd));
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CLEAR;
        t_d = '0;
      end
      CLEAR: state_d = FEED;
      FEED: if (!stall) begin
        state_d = feed_last ? DRAIN : FEED;
        t_d = feed_last ? '0 : cnt_t'(t_q + 1'b1);
      end
      DRAIN: if (!stall) begin
        state_d = drain_last ? DONE : DRAIN;
        t_d = drain_last ? '0 : cnt_t'(t_q + 1'b1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Lanes are registered, so each edge loads the beat that belongs to the next state/t.
  // A stall holds state and t, and the buffers cannot change outside IDLE, so the lanes hold too.
  always_comb
    for (int i = 0; i < MAX_DIM; i++) begin
      a_row[i] = dim_t'(i);
      a_elem[i] = dim_t'(int'(t_d) - i);
      b_row[i] = dim_t'(int'(t_d) - i);
      b_elem[i] = dim_t'(i);
      a_ok[i] = state_d == FEED && int'(t_d) >= i && int'(t_d) - i <= int'(k_q) && i <= int'(n_q);
      b_ok[i] = state_d == FEED && int'(t_d) >= i && int'(t_d) - i <= int'(k_q) && i <= int'(m_q);
    end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q <= '0;
      n_q <= '0;
      k_q <= '0;
      m_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      if (state_q == IDLE && start_i) begin
        n_q <= dim_n_i;
        k_q <= dim_k_i;
        m_q <= dim_m_i;
      end
      for (int i = 0; i < MAX_DIM; i++) begin
        a_q[i] <= a_ok[i] ? a_rd[i] : '0;
        b_q[i] <= b_ok[i] ? b_rd[i] : '0;
      end
    end
  assign a_feed_o = a_q;
  assign b_feed_o = b_q;
  assign feed_valid_o = (state_q == FEED || state_q == DRAIN) && !stall;
  assign acc_clr_o = state_q == CLEAR;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
endmodule
